// File: rtl/reg_file_if.sv
// Register-file port bundle.
// Decode/writeback side drives master; reg_file takes slave.
interface reg_file_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic            rs1_rden;
  logic [4:0]      rs2_addr;
  logic            rs2_rden;
  logic            stall;
  logic [4:0]      rd_addr;
  logic            rd_wren;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_valid;
  logic            rs2_valid;

  modport master (
    output rs1_addr, rs1_rden,
    output rs2_addr, rs2_rden,
    output stall,
    output rd_addr, rd_wren, rd_data,
    input  rs1_data, rs2_data,
    input  rs1_valid, rs2_valid
  );

  modport slave (
    input  rs1_addr, rs1_rden,
    input  rs2_addr, rs2_rden,
    input  stall,
    input  rd_addr, rd_wren, rd_data,
    output rs1_data, rs2_data,
    output rs1_valid, rs2_valid
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file: x0 hardwired zero, registered
// 2-read/1-write with same-edge bypass and stall hold.
module reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  reg_file_if.slave rf
);

  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];

  logic [XLEN-1:0] rs1_data_d, rs1_data_q;
  logic [XLEN-1:0] rs2_data_d, rs2_data_q;
  logic            rs1_valid_q, rs2_valid_q;
  logic [4:0]      rs1_hold_q, rs2_hold_q;
  logic            fwd1, fwd2;

  // Architectural state; reset wins over writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf.rd_wren && rf.rd_addr != 5'd0) begin
      regs_q[rf.rd_addr] <= rf.rd_data;
    end
  end

  // Port 1 read value, with write-before-read bypass.
  always_comb begin
    rs1_data_d = '0;
    if (rf.rs1_rden && rf.rs1_addr != 5'd0) begin
      if (rf.rd_wren && rf.rd_addr == rf.rs1_addr) begin
        rs1_data_d = rf.rd_data;
      end else begin
        rs1_data_d = regs_q[rf.rs1_addr];
      end
    end
  end

  // Port 2 read value, with write-before-read bypass.
  always_comb begin
    rs2_data_d = '0;
    if (rf.rs2_rden && rf.rs2_addr != 5'd0) begin
      if (rf.rd_wren && rf.rd_addr == rf.rs2_addr) begin
        rs2_data_d = rf.rd_data;
      end else begin
        rs2_data_d = regs_q[rf.rs2_addr];
      end
    end
  end

  // A stalled operand still picks up a late write to its register.
  always_comb begin
    fwd1 = rs1_valid_q && rf.rd_wren &&
           rs1_hold_q != 5'd0 && rf.rd_addr == rs1_hold_q;
    fwd2 = rs2_valid_q && rf.rd_wren &&
           rs2_hold_q != 5'd0 && rf.rd_addr == rs2_hold_q;
  end

  // Output operand registers and held read addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_valid_q <= 1'b0;
      rs2_valid_q <= 1'b0;
      rs1_hold_q  <= 5'd0;
      rs2_hold_q  <= 5'd0;
    end else if (!rf.stall) begin
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_valid_q <= rf.rs1_rden;
      rs2_valid_q <= rf.rs2_rden;
      rs1_hold_q  <= rf.rs1_rden ? rf.rs1_addr : 5'd0;
      rs2_hold_q  <= rf.rs2_rden ? rf.rs2_addr : 5'd0;
    end else begin
      if (fwd1) rs1_data_q <= rf.rd_data;
      if (fwd2) rs2_data_q <= rf.rd_data;
    end
  end

  assign rf.rs1_data  = rs1_data_q;
  assign rf.rs2_data  = rs2_data_q;
  assign rf.rs1_valid = rs1_valid_q;
  assign rf.rs2_valid = rs2_valid_q;

endmodule
